// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among REQ_N byte-stream requesters, packet-granular.
// Optional FETCH watchdog (abort on starved valid) is built only when ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int REQ_N       = 2,
  parameter int GAP_CYC     = 2500,
  parameter int GAP_W       = 28,
  parameter int TIMEOUT_CYC = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_N-1:0]   req,
  input  logic [REQ_N-1:0]   valid,
  input  logic [8*REQ_N-1:0] data,
  input  logic [REQ_N-1:0]   last,
  output logic [REQ_N-1:0]   ack,
  output logic [REQ_N-1:0]   grant,
  output logic               pkt_done,
  output logic               err,
  output logic               uart_start,
  output logic [7:0]         uart_data,
  input  logic               uart_ready
);
  localparam int PW = 2;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_BUSY, S_DONE, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [REQ_N-1:0]   grant_q, grant_d;
  logic [REQ_N-1:0]   ack_q, ack_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               last_q, last_d;
  logic [7:0]         uart_data_q, uart_data_d;
  logic               uart_start_q, uart_start_d;
  logic               pkt_done_q, pkt_done_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
`ifdef ARB_TIMEOUT_EN
  logic [GAP_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
`endif

  logic [PW-1:0]      g_idx;
  logic [PW-1:0]      win_idx;
  logic               win_vld;
  int                 cand;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < REQ_N; i++)
      if (grant_q[i]) g_idx = PW'(i);
  end

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 1; k <= REQ_N; k++) begin
      cand = (int'(ptr_q) + k) % REQ_N;
      if (!win_vld && req[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    last_d       = last_q;
    uart_data_d  = uart_data_q;
    gap_d        = gap_q;
    ack_d        = '0;
    uart_start_d = 1'b0;
    pkt_done_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_d        = tmo_q;
    err_d        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = {{(REQ_N-1){1'b0}}, 1'b1} << win_idx;
          state_d = S_FETCH;
`ifdef ARB_TIMEOUT_EN
          tmo_d   = GAP_W'(TIMEOUT_CYC);
`endif
        end
      end
      S_FETCH: begin
        if (valid[g_idx]) begin
          uart_data_d = data[{g_idx, 3'b000} +: 8];
          last_d      = last[g_idx];
          ack_d       = grant_q;
          state_d     = S_START;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_q <= GAP_W'(1)) begin
          err_d   = 1'b1;
          grant_d = '0;
          ptr_d   = g_idx;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q - GAP_W'(1);
        end
`endif
      end
      S_START: begin
        if (uart_ready) begin
          uart_start_d = 1'b1;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!uart_ready) state_d = S_DONE;
      end
      S_DONE: begin
        if (uart_ready) begin
          gap_d   = GAP_W'(GAP_CYC);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (!last_q) begin
          state_d = S_FETCH;
`ifdef ARB_TIMEOUT_EN
          tmo_d   = GAP_W'(TIMEOUT_CYC);
`endif
        end else begin
          pkt_done_d = 1'b1;
          ptr_d      = g_idx;
          grant_d    = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      ack_q        <= '0;
      ptr_q        <= PW'(REQ_N-1);
      last_q       <= 1'b0;
      uart_data_q  <= 8'h00;
      uart_start_q <= 1'b0;
      pkt_done_q   <= 1'b0;
      gap_q        <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      ptr_q        <= ptr_d;
      last_q       <= last_d;
      uart_data_q  <= uart_data_d;
      uart_start_q <= uart_start_d;
      pkt_done_q   <= pkt_done_d;
      gap_q        <= gap_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q        <= tmo_d;
      err_q        <= err_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign ack        = ack_q;
  assign uart_start = uart_start_q;
  assign uart_data  = uart_data_q;
  assign pkt_done   = pkt_done_q;
`ifdef ARB_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues and a uart_tx model drive the DUT,
// a scoreboard of {owner, byte} is popped and compared at every uart_start.
module tb_uart_tx_arbiter;
  localparam int REQ_N = 2;
  localparam int GAP   = 4;
  localparam int BUSY  = 20;
`ifdef ARB_TIMEOUT_EN
  localparam int TMO   = 50;
`else
  localparam int TMO   = 25000000;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [REQ_N-1:0]  req = '0, valid = '0, last = '0;
  logic [8*REQ_N-1:0] data = '0;
  logic [REQ_N-1:0]  ack, grant;
  logic              pkt_done, err, uart_start;
  logic [7:0]        uart_data;
  logic              uart_ready = 1'b1;

  uart_tx_arbiter #(.REQ_N(REQ_N), .GAP_CYC(GAP), .GAP_W(28), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .valid(valid), .data(data), .last(last),
    .ack(ack), .grant(grant), .pkt_done(pkt_done), .err(err),
    .uart_start(uart_start), .uart_data(uart_data), .uart_ready(uart_ready)
  );

  always #5 clk = ~clk;

  logic [8:0] rq0[$];
  logic [8:0] rq1[$];
  logic [8:0] sb[$];
  logic [1:0] en = '0, frc = '0;
  logic       hold = 1'b0;
  logic       start_prev = 1'b0;
  logic       both_seen = 1'b0;
  int n_pass = 0, n_chk = 0;
  int n_start = 0, n_ack0 = 0, n_ack1 = 0, n_pkt = 0, n_err = 0;
  int ucnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // uart_tx model: ready drops after start, stays low BUSY clocks; hold forces it low.
  always @(posedge clk) begin
    if (hold) begin
      uart_ready <= 1'b0;
      ucnt       <= 0;
    end else if (uart_ready && uart_start) begin
      uart_ready <= 1'b0;
      ucnt       <= BUSY;
    end else if (!uart_ready) begin
      if (ucnt == 0) uart_ready <= 1'b1;
      else ucnt <= ucnt - 1;
    end
  end

  // Monitor plus requester driver; inputs only ever change on the falling edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      if (grant == 2'b11) both_seen = 1'b1;
      if (uart_start) begin
        n_start++;
        chk("start_width", start_prev, 1'b0);
        chk("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("uart_data", uart_data, e[7:0]);
          chk("grant_at_start", grant, e[8] ? 2'b10 : 2'b01);
        end
      end
      if (ack[0]) begin n_ack0++; if (rq0.size() != 0) void'(rq0.pop_front()); end
      if (ack[1]) begin n_ack1++; if (rq1.size() != 0) void'(rq1.pop_front()); end
      if (pkt_done) n_pkt++;
      if (err) n_err++;
    end
    start_prev = uart_start;
    valid[0]   = en[0] && rq0.size() != 0;
    valid[1]   = en[1] && rq1.size() != 0;
    req[0]     = en[0] && (rq0.size() != 0 || frc[0]);
    req[1]     = en[1] && (rq1.size() != 0 || frc[1]);
    data[7:0]  = rq0.size() != 0 ? rq0[0][7:0] : 8'h00;
    data[15:8] = rq1.size() != 0 ? rq1[0][7:0] : 8'h00;
    last[0]    = rq0.size() != 0 ? rq0[0][8] : 1'b0;
    last[1]    = rq1.size() != 0 ? rq1[0][8] : 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0; en = '0; frc = '0; hold = 1'b0;
    rq0.delete(); rq1.delete(); sb.delete();
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int pk, input int budget);
    int c = 0;
    while ((n_pkt < pk || sb.size() != 0 || grant != '0) && c < budget) begin
      @(negedge clk); #1; c++;
    end
    chk(tag, c < budget, 1'b1);
  endtask

  task automatic wait_ack0(input int target, input int budget);
    int c = 0;
    while (n_ack0 < target && c < budget) begin @(negedge clk); #1; c++; end
    chk("ack0_timeout", c < budget, 1'b1);
  endtask

  initial begin
    int b0, bs, bp;
    #3 rst = 1'b0;
    #1;
    chk("rst_grant", grant, '0);
    chk("rst_ack", ack, '0);
    chk("rst_start", uart_start, 1'b0);
    chk("rst_data", uart_data, 8'h00);
    chk("rst_pkt_done", pkt_done, 1'b0);
    chk("rst_err", err, 1'b0);
    @(posedge clk); #2 rst = 1'b1;

    // 1: single 3-byte packet from requester 0
    bp = n_pkt; bs = n_start; b0 = n_ack0;
    @(posedge clk); #2;
    rq0.push_back({1'b0, 8'h41}); rq0.push_back({1'b0, 8'h54}); rq0.push_back({1'b1, 8'h0D});
    sb.push_back({1'b0, 8'h41}); sb.push_back({1'b0, 8'h54}); sb.push_back({1'b0, 8'h0D});
    en = 2'b01;
    wait_ack0(b0 + 1, 200);
    @(negedge clk); #1;
    chk("t1_latency", uart_start, 1'b1);
    wait_done("t1_done", bp + 1, 2000);
    chk("t1_acks", n_ack0 - b0, 3);
    chk("t1_starts", n_start - bs, 3);
    chk("t1_pkts", n_pkt - bp, 1);
    chk("t1_grant_after", grant, '0);

    // 2: both request continuously, single-byte packets alternate 0,1,0,1
    do_reset();
    bp = n_pkt;
    for (int i = 0; i < 4; i++) begin
      rq0.push_back({1'b1, 8'hA0 + 8'(i)});
      rq1.push_back({1'b1, 8'hB0 + 8'(i)});
      sb.push_back({1'b0, 8'hA0 + 8'(i)});
      sb.push_back({1'b1, 8'hB0 + 8'(i)});
    end
    en = 2'b11;
    wait_done("t2_done", bp + 8, 4000);
    chk("t2_pkts", n_pkt - bp, 8);
    chk("t2_both_granted", both_seen, 1'b0);

    // 3: requester 1 arrives mid-packet; no interleaving
    do_reset();
    bp = n_pkt; b0 = n_ack0;
    rq0.push_back({1'b0, 8'hC1}); rq0.push_back({1'b0, 8'hC2}); rq0.push_back({1'b1, 8'hC3});
    sb.push_back({1'b0, 8'hC1}); sb.push_back({1'b0, 8'hC2}); sb.push_back({1'b0, 8'hC3});
    sb.push_back({1'b1, 8'hD1}); sb.push_back({1'b1, 8'hD2});
    en = 2'b01;
    wait_ack0(b0 + 1, 200);
    @(posedge clk); #2;
    rq1.push_back({1'b0, 8'hD1}); rq1.push_back({1'b1, 8'hD2});
    en = 2'b11;
    wait_done("t3_done", bp + 2, 4000);
    chk("t3_pkts", n_pkt - bp, 2);

    // 4: uart busy for 100 clocks at capture
    do_reset();
    bp = n_pkt; b0 = n_ack0;
    hold = 1'b1;
    rq0.push_back({1'b1, 8'h5A});
    sb.push_back({1'b0, 8'h5A});
    en = 2'b01;
    wait_ack0(b0 + 1, 200);
    bs = n_start;
    repeat (100) @(negedge clk);
    #1;
    chk("t4_no_start", n_start - bs, 0);
    chk("t4_data_held", uart_data, 8'h5A);
    @(posedge clk); #2 hold = 1'b0;
    wait_done("t4_done", bp + 1, 2000);
    chk("t4_one_start", n_start - bs, 1);

    // 5: reset during BUSY, packet restarts from the next valid byte
    do_reset();
    bp = n_pkt; bs = n_start;
    rq0.push_back({1'b0, 8'h11}); rq0.push_back({1'b1, 8'h22});
    sb.push_back({1'b0, 8'h11});
    en = 2'b01;
    begin
      int c = 0;
      while (n_start == bs && c < 200) begin @(negedge clk); #1; c++; end
      chk("t5_first_start", c < 200, 1'b1);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_rst_grant", grant, '0);
    chk("t5_rst_ack", ack, '0);
    chk("t5_rst_start", uart_start, 1'b0);
    chk("t5_rst_data", uart_data, 8'h00);
    chk("t5_rst_pkt_done", pkt_done, 1'b0);
    sb.push_back({1'b0, 8'h22});
    @(posedge clk); #2 rst = 1'b1;
    wait_done("t5_done", bp + 1, 2000);
    chk("t5_pkts", n_pkt - bp, 1);

`ifdef ARB_TIMEOUT_EN
    // 6: granted requester never supplies a byte; abort, then serve the other
    do_reset();
    bp = n_pkt;
    frc = 2'b01;
    rq1.push_back({1'b1, 8'hE7});
    sb.push_back({1'b1, 8'hE7});
    en = 2'b11;
    begin
      int c = 0;
      while (grant != 2'b01 && c < 50) begin @(negedge clk); #1; c++; end
      chk("t6_grant0", grant, 2'b01);
      c = 0;
      while (!err && c < 200) begin @(negedge clk); #1; c++; end
      chk("t6_err_time", c, 50);
      chk("t6_no_pkt_done", n_pkt - bp, 0);
    end
    @(posedge clk); #2 frc = 2'b00;
    wait_done("t6_done", bp + 1, 2000);
    chk("t6_err_count", n_err, 1);
`else
    chk("err_never", n_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx serializer between up to four byte-stream requesters, e.g. the command/data sender and a status reporter.
- Grants the UART to one requester for a whole packet, which ends at the byte flagged last.
- Arbitration is round-robin.
- Drives uart_tx start/data, honours its ready flag, and inserts a programmable idle gap between bytes.

Parameters:
REQ_N, 2, number of requesters (2..4)
GAP_CYC, 2500, idle clocks after each byte completes before the next fetch (0 = no gap)
GAP_W, 28, width of gap/timeout counters
TIMEOUT_CYC, 25000000, clocks a granted requester may leave valid low before abort (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req  in  REQ_N  per-requester packet request, level
valid  in  REQ_N  per-requester byte available
data  in  8*REQ_N  requester i byte on bits [8i+7:8i]
last  in  REQ_N  qualifies current byte as final of packet
ack  out  REQ_N  one-cycle pulse: byte of requester i captured
grant  out  REQ_N  one-hot owner of UART, held for whole packet
pkt_done  out  1  one-cycle pulse when a packet's last byte finishes its gap
err  out  1  one-cycle pulse on packet abort (optional feature; else 0)
uart_start  out  1  to uart_tx start
uart_data  out  8  to uart_tx data, stable from start until ready returns high
uart_ready  in  1  from uart_tx ready (1 = idle)

Behaviour:
- Reset (rst low, async, any state): state=IDLE; grant=0, ack=0, uart_start=0, uart_data=8'h00, pkt_done=0, err=0; rr pointer=REQ_N-1; counters=0. Any in-flight byte is dropped.
- IDLE: if |req, select next requester by round-robin.
  - Search starts at (ptr+1) mod REQ_N and wraps.
  - The winner is registered into grant next clock; go FETCH.
  - With no req, stay in IDLE.
- FETCH: if valid[g]:
  - latch data[g] into uart_data and last[g] into last_q;
  - ack[g]=1 for exactly this cycle; go START.
  - req changes while granted are ignored.
- START: wait uart_ready=1, then uart_start=1 for exactly one clock; go BUSY.
- BUSY: wait uart_ready=0; go DONE.
- DONE: wait uart_ready=1, then load gap counter=GAP_CYC; go GAP.
- GAP: decrement to 0 (GAP_CYC=0: leave immediately). Then:
  - if last_q=0: go FETCH;
  - else: pkt_done pulse, ptr=g, grant=0, go IDLE.
- Latency: FETCH capture to uart_start is 1 clock when uart_ready is already high.
- Arbitration for the next packet cannot begin before the clock after grant drops. Between packets there is at least 1 IDLE cycle with grant=0.
- Simultaneous requests: exactly one granted per packet. With all REQ_N requesters requesting continuously, each is served once per REQ_N packets.
- A single-byte packet (last=1 on first byte) is legal.
- uart_data never changes between capture and the start of the next FETCH.
- A requester may only assume its byte was taken on ack; valid held with no grant produces no ack.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - FETCH runs a counter loaded with TIMEOUT_CYC on entry.
  - If it reaches 0 with valid[g] still low: err pulses 1 clock, grant=0, ptr=g, no pkt_done, go IDLE.
  - Counter reloads on every FETCH entry.
- Undefined: FETCH waits indefinitely; err tied 0; no counter logic synthesized.

Test Plan:
1. Single requester 0, 3-byte packet 41,54,0D (last on 0D), GAP_CYC=4, model uart busy 20 clocks -> grant=01 throughout; three ack[0] pulses; uart_data 41,54,0D in order; one uart_start per byte; pkt_done once; grant 00 after.
2. req=11 asserted same clock after reset, 1-byte packets repeated 4 times each -> grant order 01,10,01,10,...; never both bits set.
3. Requester 1 raises req mid-packet of requester 0 -> requester 0 keeps grant until its last byte; requester 1 granted on the next arbitration; no byte interleaving on uart_data.
4. uart_ready held low for 100 clocks at FETCH capture -> uart_start stays 0 until ready=1, then a single 1-clock pulse; uart_data unchanged.
5. rst pulsed low during BUSY -> all outputs 0 immediately; after release, same requester re-arbitrates and restarts packet from its current valid byte.
6. ARB_TIMEOUT_EN, TIMEOUT_CYC=50, granted requester never asserts valid -> err pulse at clock 50 of FETCH, grant cleared, pkt_done not pulsed; other pending requester granted next.
